gearbox_downsizing_2x: RTL and testbench
========================================

Name: gearbox_downsizing_2x

Overview:
- Converts a wide AXI-Stream (2*nb bits per beat) into a narrow stream (nb bits per beat), emitting two narrow beats per wide beat.
- Sits directly downstream of the 2x upsizer; the upper half of each wide word is emitted first, so upsizer -> downsizer round-trips the original word order.
- Fully registered: no combinational path from out_tready to in_tready, and none from in_* to out_*.
- Sustains 1 narrow beat per cycle.

Parameters:
- n, 5: narrow word width in bytes
- nb, n*8: narrow word width in bits; the wide word is 2*nb

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset
- in_tdata  input  2*nb  wide word; [2nb-1:nb] = first half, [nb-1:0] = second half
- in_tvalid  input  1  wide word valid
- in_tready  output  1  wide word accepted when in_tvalid & in_tready
- out_tdata  output  nb  narrow word
- out_tvalid  output  1  narrow word valid
- out_tready  input  1  downstream ready
- out_tlast  output  1  high on the second (lower) half of each wide word

Behaviour:
- Clock and reset: clock aclk; reset aresetn, synchronous, active-low.
- Storage:
  - cur register (2*nb), cur_valid, phase bit (0 = upper half, 1 = lower half).
  - nxt register (2*nb), nxt_valid (skid entry).
- Outputs (all taken directly from registers):
  - out_tvalid = cur_valid.
  - out_tdata = phase ? cur[nb-1:0] : cur[2nb-1:nb].
  - out_tlast = phase.
- in_tready: a dedicated flop. Next value = ~nxt_valid_next.
- Reset values: cur_valid=0, nxt_valid=0, phase=0, in_tready=0. In the first cycle after aresetn rises, in_tready=1.
- Data registers (cur, nxt) are not reset.
- Definitions:
  - acc = in_tvalid & in_tready
  - pop = cur_valid & out_tready
  - done = pop & phase (the lower half is consumed)
- Phase: pop & ~phase -> phase=1; done -> phase=0.
- cur_valid becomes 0 on done unless refilled in the same cycle.
- Refill priority at each edge:
  - done & nxt_valid -> cur<=nxt, cur_valid=1, phase=0. If acc also, nxt<=in_tdata (nxt_valid stays 1).
  - (~cur_valid | done) & ~nxt_valid & acc -> cur<=in_tdata directly, cur_valid=1, phase=0.
  - cur_valid & ~done & acc -> nxt<=in_tdata, nxt_valid=1.
  - done & nxt_valid & ~acc -> nxt_valid=0.
- acc can never occur with nxt_valid=1 and no done, because in_tready is then 0.
- Latency: a wide word accepted at edge k into an empty block gives out_tvalid=1 with the upper half in cycle k+1.
- Throughput: with out_tready held at 1 and a continuous in_tvalid, narrow beats are emitted every cycle. in_tready may toggle, but the average accepted rate is 1 wide beat per 2 cycles.
- Backpressure:
  - out_tready=0 holds out_tdata, out_tvalid and out_tlast stable (AXI rule).
  - At most 2 wide words are buffered; in_tready=0 once both are full.
- Reset mid-operation: buffered words are discarded, phase returns to 0, and no partial half is emitted after reset.
- out_tvalid never drops without a pop.
- in_tdata is sampled only on acc.

Decomposition:
- Shared package gearbox_pkg:
  - localparam-style helpers for the nb/2*nb width relations.
  - phase encoding constants PH_UPPER=0 and PH_LOWER=1 (shared with the upsizer's half flag).
- No sub-module: the block is a single flat module of two registers plus control. The optional reuse candidate is a generic 2-entry skid buffer, but it is kept inline so in_tready stays a plain flop.

Test Plan:
- Test parameters: n=1 (nb=8).
- Single word: after reset, in_tdata=16'hA1B2 with in_tvalid for 1 cycle, out_tready=1 -> out_tdata=8'hA1 (tlast=0) in cycle k+1, then 8'hB2 (tlast=1) in cycle k+2, then out_tvalid=0.
- Streaming: in_tvalid=1 continuously with words 16'h0102, 16'h0304, 16'h0506; out_tready=1 -> out sequence 01,02,03,04,05,06 on consecutive cycles with no bubble after the first beat.
- Backpressure: load 16'hAABB and 16'hCCDD with out_tready=0 -> in_tready=0 after the second accept, out_tdata holds 8'hAA. Then out_tready=1 -> AA,BB,CC,DD, and in_tready returns to 1.
- Reset: aresetn low for 1 cycle while cur holds 16'h1122 at phase=1 -> out_tvalid=0 and in_tready=0 in the reset cycle, in_tready=1 the next cycle, and 8'h22 is never emitted.
- Loopback: chain the upsizer with this block, feed random 8-bit words with random valid/ready -> the output sequence equals the input sequence, with out_tlast on every 2nd beat.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared definitions for the 2x up/down gearboxes: width helpers and the half/phase encoding.
package gearbox_pkg;

  localparam logic PH_UPPER = 1'b0;
  localparam logic PH_LOWER = 1'b1;

  function automatic int narrow_w(input int n);
    return n * 8;
  endfunction

  function automatic int wide_w(input int nb);
    return 2 * nb;
  endfunction

endpackage

// File: rtl/gearbox_downsizing_2x_if.sv
// Wide-in / narrow-out stream pair of the 2x downsizer; master drives the wide side.
interface gearbox_downsizing_2x_if #(
  parameter int n  = 5,
  parameter int nb = n * 8
);
  logic [2*nb-1:0] in_tdata;
  logic            in_tvalid;
  logic            in_tready;
  logic [nb-1:0]   out_tdata;
  logic            out_tvalid;
  logic            out_tready;
  logic            out_tlast;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/gearbox_downsizing_2x.sv
// 2x AXI-Stream downsizer: each wide beat leaves as upper half then lower half (tlast on lower).
// Two wide entries (cur + skid nxt); every output and in_tready come straight from flops.
module gearbox_downsizing_2x
  import gearbox_pkg::*;
#(
  parameter int n  = 5,
  parameter int nb = narrow_w(n)
) (
  input  logic aclk,
  input  logic aresetn,
  gearbox_downsizing_2x_if.slave bus
);
  localparam int WW = wide_w(nb);

  logic [WW-1:0] cur, cur_d, nxt, nxt_d;
  logic          cur_valid, cur_valid_d;
  logic          nxt_valid, nxt_valid_d;
  logic          phase, phase_d;
  logic          in_rdy;
  logic          acc, pop, done;

  assign acc  = bus.in_tvalid & in_rdy;
  assign pop  = cur_valid & bus.out_tready;
  assign done = pop & (phase == PH_LOWER);

  assign bus.in_tready  = in_rdy;
  assign bus.out_tvalid = cur_valid;
  assign bus.out_tlast  = phase;
  assign bus.out_tdata  = (phase == PH_LOWER) ? cur[nb-1:0] : cur[WW-1:nb];

  always_comb begin
    cur_d       = cur;
    nxt_d       = nxt;
    cur_valid_d = cur_valid;
    nxt_valid_d = nxt_valid;
    phase_d     = phase;
    if (pop && phase == PH_UPPER) phase_d = PH_LOWER;
    if (done) begin
      cur_valid_d = 1'b0;
      phase_d     = PH_UPPER;
    end
    if (done && nxt_valid) begin
      // skid entry moves up; a same-cycle accept refills the skid slot
      cur_d       = nxt;
      cur_valid_d = 1'b1;
      if (acc) nxt_d = bus.in_tdata;
      else     nxt_valid_d = 1'b0;
    end else if ((!cur_valid || done) && !nxt_valid && acc) begin
      cur_d       = bus.in_tdata;
      cur_valid_d = 1'b1;
      phase_d     = PH_UPPER;
    end else if (cur_valid && !done && acc) begin
      nxt_d       = bus.in_tdata;
      nxt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      phase     <= PH_UPPER;
      in_rdy    <= 1'b0;
    end else begin
      cur_valid <= cur_valid_d;
      nxt_valid <= nxt_valid_d;
      phase     <= phase_d;
      in_rdy    <= ~nxt_valid_d;
    end
  end

  // Data registers carry no reset; the valid bits gate them.
  always_ff @(posedge aclk) begin
    cur <= cur_d;
    nxt <= nxt_d;
  end

endmodule

// File: tb/tb_gearbox_downsizing_2x.sv
// Scoreboard bench for the 2x downsizer: each accepted wide word queues its two expected halves.
module tb_gearbox_downsizing_2x;
  localparam int N  = 1;
  localparam int NB = 8;

  logic aclk;
  logic aresetn;

  gearbox_downsizing_2x_if #(.n(N)) bus ();

  gearbox_downsizing_2x #(.n(N)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks;
  int errors;
  int cyc;
  int acc_cyc;
  logic [NB:0] exp_q[$];
  int pop_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: pops/compares presented beats, records accepted words, checks stall stability.
  task automatic monitor();
    logic       stalled = 1'b0;
    logic [NB:0] held = '0;
    logic [NB:0] e;
    forever begin
      @(negedge aclk);
      cyc++;
      if (stalled) begin
        chk("hold_valid", bus.out_tvalid, 1);
        chk("hold_beat", {bus.out_tlast, bus.out_tdata}, held);
      end
      stalled = aresetn && bus.out_tvalid && !bus.out_tready;
      held    = {bus.out_tlast, bus.out_tdata};
      if (!aresetn) begin
        exp_q.delete();
      end else begin
        if (bus.out_tvalid && bus.out_tready) begin
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {bus.out_tlast, bus.out_tdata}, 9'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {bus.out_tlast, bus.out_tdata}, e);
          end
        end
        if (bus.in_tvalid && bus.in_tready) begin
          acc_cyc = cyc;
          exp_q.push_back({1'b0, bus.in_tdata[2*NB-1:NB]});
          exp_q.push_back({1'b1, bus.in_tdata[NB-1:0]});
        end
      end
    end
  endtask

  task automatic send_word(input logic [2*NB-1:0] w);
    bus.in_tdata  = w;
    bus.in_tvalid = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge aclk);
      if (bus.in_tready) begin
        @(posedge aclk);
        #1;
        return;
      end
    end
    fail("send_timeout");
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge aclk);
    #1;
  endtask

  initial begin
    logic acc_now;
    int   first_acc;
    checks = 0;
    errors = 0;
    cyc    = 0;
    acc_cyc = 0;
    aresetn        = 1'b0;
    bus.in_tdata   = '0;
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    tick(2);
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_in_tready", bus.in_tready, 0);
    aresetn = 1'b1;
    tick(1);
    chk("post_rst_in_tready", bus.in_tready, 1);

    // single word, latency and trailing idle
    bus.out_tready = 1'b1;
    pop_cyc.delete();
    send_word(16'hA1B2);
    first_acc = acc_cyc;
    bus.in_tvalid = 1'b0;
    tick(4);
    chk("single_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) begin
      chk("single_latency", pop_cyc[0] - first_acc, 1);
      chk("single_back2back", pop_cyc[1] - pop_cyc[0], 1);
    end
    chk("single_idle", bus.out_tvalid, 0);

    // streaming, no bubbles after first beat
    pop_cyc.delete();
    send_word(16'h0102);
    send_word(16'h0304);
    send_word(16'h0506);
    bus.in_tvalid = 1'b0;
    tick(8);
    chk("stream_pops", pop_cyc.size(), 6);
    if (pop_cyc.size() == 6) chk("stream_span", pop_cyc[5] - pop_cyc[0], 5);

    // backpressure: two words buffered, in_tready drops, head holds
    bus.out_tready = 1'b0;
    send_word(16'hAABB);
    send_word(16'hCCDD);
    bus.in_tvalid = 1'b0;
    @(negedge aclk);
    chk("bp_in_tready", bus.in_tready, 0);
    chk("bp_head", {bus.out_tvalid, bus.out_tlast, bus.out_tdata}, {2'b10, 8'hAA});
    tick(3);
    @(negedge aclk);
    chk("bp_head_held", bus.out_tdata, 8'hAA);
    tick(1);
    bus.out_tready = 1'b1;
    tick(6);
    chk("bp_drain_ready", bus.in_tready, 1);
    chk("bp_drained", exp_q.size(), 0);

    // reset with lower half pending: 8'h22 must never appear
    bus.out_tready = 1'b0;
    send_word(16'h1122);
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 1'b1;
    tick(1);
    bus.out_tready = 1'b0;
    @(negedge aclk);
    chk("pre_rst_lower", {bus.out_tvalid, bus.out_tlast, bus.out_tdata}, {2'b11, 8'h22});
    tick(1);
    aresetn = 1'b0;
    tick(1);
    chk("midrst_out_tvalid", bus.out_tvalid, 0);
    chk("midrst_in_tready", bus.in_tready, 0);
    aresetn = 1'b1;
    tick(1);
    chk("midrst_release_ready", bus.in_tready, 1);
    bus.out_tready = 1'b1;
    tick(4);
    chk("midrst_no_partial", bus.out_tvalid, 0);

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      acc_now = bus.in_tvalid & bus.in_tready;
      @(posedge aclk);
      #1;
      if (acc_now || !bus.in_tvalid) begin
        bus.in_tvalid = ($urandom_range(0, 3) != 0);
        bus.in_tdata  = 16'($urandom);
      end
      bus.out_tready = ($urandom_range(0, 3) != 0);
    end
    @(negedge aclk);
    acc_now = bus.in_tvalid & bus.in_tready;
    @(posedge aclk);
    #1;
    if (!acc_now) begin
      for (int t = 0; t < 1000 && bus.in_tvalid; t++) begin
        @(negedge aclk);
        acc_now = bus.in_tready;
        @(posedge aclk);
        #1;
        if (acc_now) bus.in_tvalid = 1'b0;
      end
    end
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick(1);
    tick(2);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", bus.out_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
